// File: rtl/cnn_argmax_pkg.sv
// Shared constants and state encoding for the 9-way argmax stage.
package cnn_argmax_pkg;

   localparam int unsigned NUM_CLASSES = 9;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned IMG_W       = 5;
   localparam int unsigned LOG_DEPTH   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_e;

endpackage

// File: rtl/cnn_argmax_result_log.sv
// Tag-indexed result log: one class index per image tag, with a per-entry written flag.
module cnn_argmax_result_log
   import cnn_argmax_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_wr_en,
   input  logic [IMG_W-1:0]     i_wr_addr,
   input  logic [IDX_W-1:0]     i_wr_data,
   input  logic [IMG_W-1:0]     i_rd_addr,
   output logic [IDX_W-1:0]     o_rd_data,
   output logic [LOG_DEPTH-1:0] o_valid
);

   logic [IDX_W-1:0]     r_mem [LOG_DEPTH];
   logic [IDX_W-1:0]     r_rd_data;
   logic [LOG_DEPTH-1:0] r_valid;

   // Read samples r_mem before this edge's write lands, so a colliding read sees old data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < LOG_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_valid   <= '0;
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
         if (i_wr_en) begin
            r_mem[i_wr_addr]   <= i_wr_data;
            r_valid[i_wr_addr] <= 1'b1;
         end
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_valid   = r_valid;

endmodule

// File: rtl/cnn_argmax_unit.sv
// Sequential 9-way signed argmax over captured dense scores; one score per cycle.
// Optional tag-indexed result log enabled by defining ARGMAX_RESULT_LOG_EN.
module cnn_argmax_unit
   import cnn_argmax_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 argmax_start,
   input  logic [DATA_W-1:0]    argmax_data_in0,
   input  logic [DATA_W-1:0]    argmax_data_in1,
   input  logic [DATA_W-1:0]    argmax_data_in2,
   input  logic [DATA_W-1:0]    argmax_data_in3,
   input  logic [DATA_W-1:0]    argmax_data_in4,
   input  logic [DATA_W-1:0]    argmax_data_in5,
   input  logic [DATA_W-1:0]    argmax_data_in6,
   input  logic [DATA_W-1:0]    argmax_data_in7,
   input  logic [DATA_W-1:0]    argmax_data_in8,
   input  logic [IMG_W-1:0]     argmax_img,
   output logic                 argmax_done,
   output logic [IDX_W-1:0]     argmax_max_index,
   output logic [DATA_W-1:0]    argmax_max_value,
   output logic [IMG_W-1:0]     argmax_result_img,
   output logic                 argmax_busy
`ifdef ARGMAX_RESULT_LOG_EN
   ,
   input  logic [IMG_W-1:0]     log_rd_addr,
   output logic [IDX_W-1:0]     log_rd_data,
   output logic [LOG_DEPTH-1:0] log_valid
`endif
);

   argmax_state_e              r_state;
   logic signed [DATA_W-1:0]   r_buf [NUM_CLASSES];
   logic [IDX_W-1:0]           r_scan_idx;
   logic signed [DATA_W-1:0]   r_best_val;
   logic [IDX_W-1:0]           r_best_idx;
   logic [IMG_W-1:0]           r_img;
   logic                       r_done;
   logic                       r_busy;
   logic [IDX_W-1:0]           r_max_index;
   logic [DATA_W-1:0]          r_max_value;
   logic [IMG_W-1:0]           r_result_img;
   logic signed [DATA_W-1:0]   w_cand;
   logic                       w_last;

   assign w_cand = r_buf[r_scan_idx];
   assign w_last = (r_scan_idx == IDX_W'(NUM_CLASSES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            r_buf[i] <= '0;
         end
         r_scan_idx   <= '0;
         r_best_val   <= '0;
         r_best_idx   <= '0;
         r_img        <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_max_index  <= '0;
         r_max_value  <= '0;
         r_result_img <= '0;
      end else begin
         r_done <= 1'b0;
         // Busy covers the SCAN cycles plus the done cycle that follows DONE.
         r_busy <= (r_state == SCAN) || (r_state == DONE);
         case (r_state)
            IDLE: begin
               // The done cycle is spent in IDLE; holding off here keeps restarts after it.
               if (argmax_start && !r_done) begin
                  r_buf[0]   <= argmax_data_in0;
                  r_buf[1]   <= argmax_data_in1;
                  r_buf[2]   <= argmax_data_in2;
                  r_buf[3]   <= argmax_data_in3;
                  r_buf[4]   <= argmax_data_in4;
                  r_buf[5]   <= argmax_data_in5;
                  r_buf[6]   <= argmax_data_in6;
                  r_buf[7]   <= argmax_data_in7;
                  r_buf[8]   <= argmax_data_in8;
                  r_img      <= argmax_img;
                  r_best_val <= argmax_data_in0;
                  r_best_idx <= '0;
                  r_scan_idx <= IDX_W'(1);
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               // Strict compare keeps the lowest index on ties.
               if (w_cand > r_best_val) begin
                  r_best_val <= w_cand;
                  r_best_idx <= r_scan_idx;
               end
               if (w_last) begin
                  r_state <= DONE;
               end else begin
                  r_scan_idx <= r_scan_idx + IDX_W'(1);
               end
            end
            DONE: begin
               r_done       <= 1'b1;
               r_max_index  <= r_best_idx;
               r_max_value  <= r_best_val;
               r_result_img <= r_img;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign argmax_done       = r_done;
   assign argmax_max_index  = r_max_index;
   assign argmax_max_value  = r_max_value;
   assign argmax_result_img = r_result_img;
   assign argmax_busy       = r_busy;

`ifdef ARGMAX_RESULT_LOG_EN
   logic w_log_wr;

   assign w_log_wr = (r_state == DONE);

   cnn_argmax_result_log u_result_log (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_wr_en   (w_log_wr),
      .i_wr_addr (r_img),
      .i_wr_data (r_best_idx),
      .i_rd_addr (log_rd_addr),
      .o_rd_data (log_rd_data),
      .o_valid   (log_valid)
   );
`endif

endmodule

// File: tb/tb_cnn_argmax_unit.sv
// Directed self-checking bench for cnn_argmax_unit; log checks built with ARGMAX_RESULT_LOG_EN.
module tb_cnn_argmax_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] d [9];
   logic [4:0]  img;
   logic        done;
   logic [3:0]  max_index;
   logic [31:0] max_value;
   logic [4:0]  result_img;
   logic        busy;
`ifdef ARGMAX_RESULT_LOG_EN
   logic [4:0]  log_rd_addr;
   logic [3:0]  log_rd_data;
   logic [31:0] log_valid;
`endif

   int n_checks = 0;
   int n_errors = 0;

   cnn_argmax_unit dut (
      .clk               (clk),
      .reset             (reset),
      .argmax_start      (start),
      .argmax_data_in0   (d[0]),
      .argmax_data_in1   (d[1]),
      .argmax_data_in2   (d[2]),
      .argmax_data_in3   (d[3]),
      .argmax_data_in4   (d[4]),
      .argmax_data_in5   (d[5]),
      .argmax_data_in6   (d[6]),
      .argmax_data_in7   (d[7]),
      .argmax_data_in8   (d[8]),
      .argmax_img        (img),
      .argmax_done       (done),
      .argmax_max_index  (max_index),
      .argmax_max_value  (max_value),
      .argmax_result_img (result_img),
      .argmax_busy       (busy)
`ifdef ARGMAX_RESULT_LOG_EN
      ,
      .log_rd_addr       (log_rd_addr),
      .log_rd_data       (log_rd_data),
      .log_valid         (log_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_basic_scores();
      d[0] = 32'h0001_0000; d[1] = 32'h0005_0000; d[2] = 32'h0003_0000;
      d[3] = 32'h0002_0000; d[4] = 32'h0009_0000; d[5] = 32'h0000_0000;
      d[6] = 32'h0004_0000; d[7] = 32'h0007_0000; d[8] = 32'h0006_0000;
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int i = 0; i < 9; i++) d[i] = v;
   endtask

   // Pulses start for one cycle (edge T) then watches 14 edges after T.
   task automatic run_op(input logic [4:0] tag, output int done_at, output int n_done,
                         output int n_busy);
      @(negedge clk);
      img   = tag;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_at = -1; n_done = 0; n_busy = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         if (busy) n_busy++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      img   = '0;
      set_all(32'h1234_5678);
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (max_index !== 4'd0) begin n_errors++; $display("FAIL reset_index got=%0d exp=0", max_index); end
      n_checks++; if (max_value !== 32'd0) begin n_errors++; $display("FAIL reset_value got=%h exp=0", max_value); end
      n_checks++; if (result_img !== 5'd0) begin n_errors++; $display("FAIL reset_img got=%0d exp=0", result_img); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int done_at, n_done, n_busy;
      set_basic_scores();
      run_op(5'd3, done_at, n_done, n_busy);
      n_checks++; if (done_at !== 9) begin n_errors++; $display("FAIL basic_latency got=%0d exp=9", done_at); end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
      n_checks++; if (n_busy !== 9) begin n_errors++; $display("FAIL basic_busy_cycles got=%0d exp=9", n_busy); end
      n_checks++; if (max_index !== 4'd4) begin n_errors++; $display("FAIL basic_index got=%0d exp=4", max_index); end
      n_checks++; if (max_value !== 32'h0009_0000) begin n_errors++; $display("FAIL basic_value got=%h exp=00090000", max_value); end
      n_checks++; if (result_img !== 5'd3) begin n_errors++; $display("FAIL basic_img got=%0d exp=3", result_img); end
   endtask

   task automatic test_boundaries();
      int done_at, n_done, n_busy;
      set_all(32'hFFFF_0000);
      run_op(5'd1, done_at, n_done, n_busy);
      n_checks++; if (max_index !== 4'd0) begin n_errors++; $display("FAIL equal_index got=%0d exp=0", max_index); end
      n_checks++; if (max_value !== 32'hFFFF_0000) begin n_errors++; $display("FAIL equal_value got=%h exp=ffff0000", max_value); end
      set_all(32'h8000_0000);
      d[8] = 32'h8000_0001;
      run_op(5'd2, done_at, n_done, n_busy);
      n_checks++; if (max_index !== 4'd8) begin n_errors++; $display("FAIL min_last_index got=%0d exp=8", max_index); end
      n_checks++; if (max_value !== 32'h8000_0001) begin n_errors++; $display("FAIL min_last_value got=%h exp=80000001", max_value); end
      n_checks++; if (result_img !== 5'd2) begin n_errors++; $display("FAIL min_last_img got=%0d exp=2", result_img); end
   endtask

   task automatic test_tie();
      int done_at, n_done, n_busy;
      set_all(32'h0);
      d[2] = 32'h7FFF_FFFF;
      d[6] = 32'h7FFF_FFFF;
      run_op(5'd9, done_at, n_done, n_busy);
      n_checks++; if (max_index !== 4'd2) begin n_errors++; $display("FAIL tie_index got=%0d exp=2", max_index); end
      n_checks++; if (max_value !== 32'h7FFF_FFFF) begin n_errors++; $display("FAIL tie_value got=%h exp=7fffffff", max_value); end
   endtask

   task automatic test_restart_ignored();
      int done_at, n_done;
      set_basic_scores();
      @(negedge clk);
      img   = 5'd11;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_at = -1; n_done = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         if (k == 3) begin
            set_all(32'h0);
            d[1]  = 32'h7FFF_FFFF;
            img   = 5'd30;
            start = 1'b1;
         end else if (k == 4) begin
            start = 1'b0;
         end
      end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL restart_done_count got=%0d exp=1", n_done); end
      n_checks++; if (done_at !== 9) begin n_errors++; $display("FAIL restart_latency got=%0d exp=9", done_at); end
      n_checks++; if (max_index !== 4'd4) begin n_errors++; $display("FAIL restart_index got=%0d exp=4", max_index); end
      n_checks++; if (max_value !== 32'h0009_0000) begin n_errors++; $display("FAIL restart_value got=%h exp=00090000", max_value); end
      n_checks++; if (result_img !== 5'd11) begin n_errors++; $display("FAIL restart_img got=%0d exp=11", result_img); end
   endtask

   task automatic test_reset_mid_scan();
      int done_at, n_done, n_busy;
      set_basic_scores();
      @(negedge clk);
      img   = 5'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_done = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
         if (k == 3) reset = 1'b1;
         else if (k == 4) reset = 1'b0;
      end
      n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL abort_done_count got=%0d exp=0", n_done); end
      n_checks++; if (max_index !== 4'd0) begin n_errors++; $display("FAIL abort_index got=%0d exp=0", max_index); end
      n_checks++; if (max_value !== 32'd0) begin n_errors++; $display("FAIL abort_value got=%h exp=0", max_value); end
      n_checks++; if (result_img !== 5'd0) begin n_errors++; $display("FAIL abort_img got=%0d exp=0", result_img); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      set_all(32'h0);
      d[7] = 32'h0000_0100;
      run_op(5'd6, done_at, n_done, n_busy);
      n_checks++; if (done_at !== 9) begin n_errors++; $display("FAIL fresh_latency got=%0d exp=9", done_at); end
      n_checks++; if (max_index !== 4'd7) begin n_errors++; $display("FAIL fresh_index got=%0d exp=7", max_index); end
      n_checks++; if (result_img !== 5'd6) begin n_errors++; $display("FAIL fresh_img got=%0d exp=6", result_img); end
   endtask

`ifdef ARGMAX_RESULT_LOG_EN
   task automatic test_log();
      int done_at, n_done, n_busy;
      // Clear entries written by earlier scenarios.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_basic_scores();
      run_op(5'd7, done_at, n_done, n_busy);
      set_all(32'h0);
      d[8] = 32'h0000_0064;
      run_op(5'd20, done_at, n_done, n_busy);
      @(negedge clk);
      log_rd_addr = 5'd7;
      @(posedge clk);
      #1;
      n_checks++; if (log_rd_data !== 4'd4) begin n_errors++; $display("FAIL log_read7 got=%0d exp=4", log_rd_data); end
      @(negedge clk);
      log_rd_addr = 5'd20;
      @(posedge clk);
      #1;
      n_checks++; if (log_rd_data !== 4'd8) begin n_errors++; $display("FAIL log_read20 got=%0d exp=8", log_rd_data); end
      n_checks++; if (log_valid !== 32'h0010_0080) begin n_errors++; $display("FAIL log_valid got=%h exp=00100080", log_valid); end
   endtask
`endif

   initial begin
`ifdef ARGMAX_RESULT_LOG_EN
      log_rd_addr = '0;
`endif
      test_reset();
      test_basic();
      test_boundaries();
      test_tie();
      test_restart_ignored();
      test_reset_mid_scan();
`ifdef ARGMAX_RESULT_LOG_EN
      test_log();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
